// File: rtl/stack_core.sv
// rtl/stack_core.sv - zero-address stack-machine core with bounded operand stack and sticky fault
module stack_core #(
    parameter int DW = 8,
    parameter int DEPTH = 8,
    localparam int AW = DW - 3,
    localparam int SPW = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic           mem_we,
    input  logic [DW-1:0]  mem_rdata,
    output logic [2:0]     opcode,
    output logic [AW-1:0]  pc,
    output logic [SPW-1:0] sp,
    output logic [DW-1:0]  top,
    output logic           halted,
    output logic [1:0]     fault
);
    localparam int IW = $clog2(DEPTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    state_t         state, state_nxt;
    logic [DW-1:0]  ir;
    logic [DW-1:0]  a_reg, b_reg;
    logic [DW-1:0]  stack_mem [DEPTH];
    logic [2:0]     op;
    logic [AW-1:0]  operand;
    logic [IW-1:0]  idx_top, idx_next;
    logic           is_alu2, need_one, dec_under, dec_over, dec_fault;
    logic [DW-1:0]  alu_r;
    logic           stk_we;
    logic [IW-1:0]  stk_widx;
    logic [DW-1:0]  stk_wdata;

    assign op       = ir[DW-1:DW-3];
    assign operand  = ir[AW-1:0];
    // Low-bit arithmetic is exact here because sp-1 and sp-2 always fit in IW bits when used.
    assign idx_top  = sp[IW-1:0] - IW'(1);
    assign idx_next = sp[IW-1:0] - IW'(2);

    assign is_alu2   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    assign need_one  = (op == OP_NOT) || (op == OP_POP) || (op == OP_JZ);
    assign dec_under = (is_alu2 && (sp < SPW'(2))) || (need_one && (sp == '0));
    assign dec_over  = (op == OP_PUSH) && (sp == SPW'(DEPTH));
    assign dec_fault = dec_under || dec_over;

    // Top-of-stack view; empty stack reads as zero
    always_comb begin
        top = '0;
        if (sp != '0) top = stack_mem[idx_top];
    end

    // ALU result; B is the entry below the top, A was the top
    always_comb begin
        case (op)
            OP_ADD:  alu_r = b_reg + a_reg;
            OP_SUB:  alu_r = b_reg - a_reg;
            OP_AND:  alu_r = b_reg & a_reg;
            default: alu_r = ~a_reg;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec_fault)                          state_nxt = S_HALT;
                else if (is_alu2 || (op == OP_NOT))     state_nxt = S_EXEC;
                else                                    state_nxt = S_FETCH;
            end
            S_EXEC:   state_nxt = S_FETCH;
            default:  state_nxt = S_HALT;
        endcase
    end

    // Memory and status outputs; reset gates the write strobe combinationally
    always_comb begin
        mem_addr  = '0;
        if (state == S_FETCH)  mem_addr = pc;
        if (state == S_DECODE) mem_addr = operand;
        mem_wdata = top;
        mem_we    = rst_n && (state == S_DECODE) && (op == OP_POP) && !dec_under;
        opcode    = op;
        halted    = (state == S_HALT);
    end

    // Stack RAM write port selection: PUSH loads memory data, EXEC stores the ALU result
    always_comb begin
        stk_we    = 1'b0;
        stk_widx  = sp[IW-1:0];
        stk_wdata = mem_rdata;
        if (rst_n) begin
            if ((state == S_DECODE) && (op == OP_PUSH) && !dec_fault) begin
                stk_we = 1'b1;
            end else if (state == S_EXEC) begin
                stk_we    = 1'b1;
                stk_wdata = alu_r;
            end
        end
    end

    // Stack RAM; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (stk_we) stack_mem[stk_widx] <= stk_wdata;
    end

    // Architectural registers: PC, IR, stack pointer, operand latches, sticky fault
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= '0;
            ir    <= '0;
            sp    <= '0;
            a_reg <= '0;
            b_reg <= '0;
            fault <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= mem_rdata;
                    pc <= pc + AW'(1);
                end
                S_DECODE: begin
                    if (dec_under) begin
                        fault <= 2'b01;
                    end else if (dec_over) begin
                        fault <= 2'b10;
                    end else begin
                        case (op)
                            OP_ADD, OP_SUB, OP_AND: begin
                                a_reg <= top;
                                b_reg <= stack_mem[idx_next];
                                sp    <= sp - SPW'(2);
                            end
                            OP_NOT: begin
                                a_reg <= top;
                                sp    <= sp - SPW'(1);
                            end
                            OP_PUSH: sp <= sp + SPW'(1);
                            OP_POP:  sp <= sp - SPW'(1);
                            OP_JMP:  pc <= operand;
                            default: begin
                                sp <= sp - SPW'(1);
                                if (top == '0) pc <= operand;
                            end
                        endcase
                    end
                end
                S_EXEC: sp <= sp + SPW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_core.sv
// tb/tb_stack_core.sv - randomized and directed checks of stack_core against an instruction-level model
module tb_stack_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic [2:0] opcode;
    logic [4:0] pc;
    logic [3:0] sp;
    logic [7:0] top;
    logic       halted;
    logic [1:0] fault;

    logic [7:0] mem [32];
    logic       ld_we = 1'b0;
    logic [4:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    logic [7:0] mmem [32];
    logic [7:0] mstk [$];
    logic [4:0] mpc;
    logic [1:0] mfault;
    bit         mhalt;

    int n_cmp = 0;
    int n_bad = 0;

    stack_core #(.DW(8), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .opcode(opcode), .pc(pc), .sp(sp), .top(top), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr] <= mem_wdata;
        else if (ld_we) mem[ld_addr]  <= ld_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mtop();
        if (mstk.size() == 0) return 8'h00;
        return mstk[$];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mmem[i] = 8'h00;
    endtask

    // Hold reset, copy the model image into memory, check reset outputs, release
    task automatic start_test();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = 5'(i);
            ld_data = mmem[i];
        end
        @(negedge clk);
        ld_we = 1'b0;
        chk("rst_pc", pc, 0);
        chk("rst_sp", sp, 0);
        chk("rst_top", top, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_we", mem_we, 0);
        rst_n = 1'b1;
    endtask

    // Instruction-level model with per-instruction latency, compared every cycle
    task automatic run_prog(input int max_instr);
        logic [7:0] instr, ta, tb2, r;
        logic [2:0] op;
        logic [4:0] opa;
        bit         wexp;
        int         lat, nbad;
        mpc = 5'd0;
        mstk.delete();
        mfault = 2'b00;
        mhalt = 1'b0;
        r = 8'h00;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int n = 0; n < max_instr && !mhalt; n++) begin
            chk("fetch_we", mem_we, 0);
            chk("fetch_halted", halted, 0);
            instr = mmem[mpc];
            mpc   = mpc + 5'd1;
            op    = instr[7:5];
            opa   = instr[4:0];
            wexp  = 1'b0;
            lat   = 2;
            @(negedge clk);
            chk("dec_opcode", opcode, op);
            chk("dec_pc", pc, mpc);
            chk("dec_halted", halted, 0);
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    if (mstk.size() < 2) mfault = 2'b01;
                    else begin
                        ta  = mstk.pop_back();
                        tb2 = mstk.pop_back();
                        if (op == 3'd0)      r = tb2 + ta;
                        else if (op == 3'd1) r = tb2 - ta;
                        else                 r = tb2 & ta;
                        lat = 3;
                    end
                end
                3'd3: begin
                    if (mstk.size() < 1) mfault = 2'b01;
                    else begin
                        ta  = mstk.pop_back();
                        r   = ~ta;
                        lat = 3;
                    end
                end
                3'd4: begin
                    if (mstk.size() == 8) mfault = 2'b10;
                    else mstk.push_back(mmem[opa]);
                end
                3'd5: begin
                    if (mstk.size() == 0) mfault = 2'b01;
                    else begin
                        wexp = 1'b1;
                        chk("pop_addr", mem_addr, opa);
                        chk("pop_wdata", mem_wdata, mtop());
                        mmem[opa] = mstk.pop_back();
                    end
                end
                3'd6: mpc = opa;
                default: begin
                    if (mstk.size() == 0) mfault = 2'b01;
                    else begin
                        ta = mstk.pop_back();
                        if (ta == 8'h00) mpc = opa;
                    end
                end
            endcase
            mhalt = (mfault != 2'b00);
            chk("dec_we", mem_we, wexp);
            if (lat == 3) begin
                @(negedge clk);
                chk("exec_we", mem_we, 0);
                mstk.push_back(r);
            end
            @(negedge clk);
            chk("arch_pc", pc, mpc);
            chk("arch_sp", sp, mstk.size());
            chk("arch_top", top, mtop());
            chk("arch_fault", fault, mfault);
            chk("arch_halted", halted, mhalt);
        end
        if (mhalt) begin
            repeat (3) begin
                @(negedge clk);
                chk("halt_stay", halted, 1);
                chk("halt_we", mem_we, 0);
                chk("halt_pc", pc, mpc);
            end
        end
        nbad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== mmem[i]) nbad++;
        chk("mem_image", nbad, 0);
    endtask

    initial begin
        logic [2:0] rop;
        int         sel;

        // ADD program: 3 + 250, store to 18, then JMP 4 loops
        clear_model();
        mmem[0] = 8'h90; mmem[1] = 8'h91; mmem[2] = 8'h00; mmem[3] = 8'hB2; mmem[4] = 8'hC4;
        mmem[16] = 8'd3; mmem[17] = 8'd250;
        start_test();
        run_prog(8);
        chk("add_mem18", mem[18], 253);
        chk("add_model18", mmem[18], 253);
        chk("add_pc", pc, 4);
        chk("add_sp", sp, 0);
        chk("add_fault", fault, 0);

        // SUB: next minus top
        clear_model();
        mmem[0] = 8'h90; mmem[1] = 8'h91; mmem[2] = 8'h20; mmem[3] = 8'hB2; mmem[4] = 8'hC4;
        mmem[16] = 8'd3; mmem[17] = 8'd5;
        start_test();
        run_prog(6);
        chk("sub_mem18", mem[18], 8'hFE);

        // NOT
        clear_model();
        mmem[0] = 8'h90; mmem[1] = 8'h60; mmem[2] = 8'hB2; mmem[3] = 8'hC3;
        mmem[16] = 8'h0F;
        start_test();
        run_prog(5);
        chk("not_mem18", mem[18], 8'hF0);

        // ADD on empty stack underflows
        clear_model();
        start_test();
        run_prog(1);
        chk("uf_halted", halted, 1);
        chk("uf_fault", fault, 1);
        chk("uf_sp", sp, 0);
        chk("uf_pc", pc, 1);

        // Nine pushes overflow on the ninth
        clear_model();
        for (int i = 0; i < 9; i++) mmem[i] = 8'h90;
        mmem[16] = 8'h5A;
        start_test();
        run_prog(9);
        chk("of_halted", halted, 1);
        chk("of_fault", fault, 2);
        chk("of_sp", sp, 8);
        chk("of_pc", pc, 9);
        chk("of_top", top, 8'h5A);

        // JZ taken and not taken
        for (int v = 0; v < 2; v++) begin
            clear_model();
            mmem[0] = 8'h90; mmem[1] = 8'hE7; mmem[16] = 8'(v);
            start_test();
            run_prog(2);
            chk("jz_pc", pc, (v == 0) ? 7 : 2);
            chk("jz_sp", sp, 0);
        end

        // JMP 31 then fetch at 31 wraps PC to 0
        clear_model();
        mmem[0] = 8'hDF; mmem[31] = 8'h90;
        start_test();
        run_prog(2);
        chk("wrap_pc", pc, 0);
        chk("wrap_sp", sp, 1);

        // Reset during the DECODE cycle of POP 18 aborts the write
        clear_model();
        mmem[0] = 8'h90; mmem[1] = 8'hB2; mmem[16] = 8'h33; mmem[18] = 8'h77;
        start_test();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rpop_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rpop_we_in_reset", mem_we, 0);
        @(negedge clk);
        chk("rpop_mem18", mem[18], 8'h77);
        chk("rpop_pc", pc, 0);
        chk("rpop_sp", sp, 0);
        chk("rpop_fault", fault, 0);
        chk("rpop_halted", halted, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rpop_idle_pc", pc, 0);
        chk("rpop_idle_halted", halted, 0);

        // Random programs
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 32; i++) begin
                sel = $urandom_range(0, 11);
                case (sel)
                    0, 1, 2, 3: rop = 3'd4;
                    4:          rop = 3'd5;
                    5:          rop = 3'd0;
                    6:          rop = 3'd1;
                    7:          rop = 3'd2;
                    8:          rop = 3'd3;
                    9:          rop = 3'd6;
                    10:         rop = 3'd7;
                    default:    rop = 3'($urandom_range(0, 7));
                endcase
                mmem[i] = {rop, 5'($urandom_range(0, 31))};
            end
            start_test();
            run_prog(40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
